// File: rtl/dunit_controller.sv
// dunit_controller
// Debug-unit sequencer that sits between a byte-stream host link and the
// pipeline debug port. It loads a program into instruction memory, runs the
// pipeline freely or one step at a time, and dumps the register file and data
// memory back to the host. It is the only driver of the pipeline dunit_* inputs.
//
// Ports
//   i_clk, i_reset_n            clock, asynchronous active-low reset
//   i_rx_data, i_rx_valid       host byte and its one-cycle strobe
//   o_tx_data, o_tx_valid       byte to host, held until i_tx_ready
//   i_tx_ready                  host link accepts the presented byte
//   i_halt                      pipeline has retired HALT (level)
//   i_dunit_reg                 register-file word, 1-cycle read latency
//   i_dunit_mem_data            data-memory word, 1-cycle read latency
//   o_dunit_clk_en              pipeline advance enable
//   o_dunit_reset_pc            hold PC at 0
//   o_dunit_w_mem               instruction-memory write strobe
//   o_dunit_addr                imem write / dmem read byte address or register index
//   o_dunit_data_if             instruction word to write
//   o_busy                      high whenever the sequencer is not idle
module dunit_controller #(
  parameter int NB_REG     = 32,
  parameter int NB_ADDR    = 5,
  parameter int NB_BYTE    = 8,
  parameter int N_DMEM     = 32,
  parameter int MAX_CYCLES = 1024
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  input  logic               i_halt,
  input  logic [NB_REG-1:0]  i_dunit_reg,
  input  logic [NB_REG-1:0]  i_dunit_mem_data,
  output logic               o_dunit_clk_en,
  output logic               o_dunit_reset_pc,
  output logic               o_dunit_w_mem,
  output logic [NB_REG-1:0]  o_dunit_addr,
  output logic [NB_REG-1:0]  o_dunit_data_if,
  output logic               o_busy
);

  localparam int NB_REGS = 2 ** NB_ADDR;
  localparam logic [31:0] MAX_C = MAX_CYCLES[31:0];

  localparam logic [NB_BYTE-1:0] CMD_LOAD = NB_BYTE'(8'h4C);
  localparam logic [NB_BYTE-1:0] CMD_RUN  = NB_BYTE'(8'h43);
  localparam logic [NB_BYTE-1:0] CMD_STEP = NB_BYTE'(8'h53);
  localparam logic [NB_BYTE-1:0] CMD_DUMP = NB_BYTE'(8'h52);
  localparam logic [NB_BYTE-1:0] RSP_OK   = NB_BYTE'(8'h4B);
  localparam logic [NB_BYTE-1:0] RSP_HALT = NB_BYTE'(8'h48);
  localparam logic [NB_BYTE-1:0] RSP_TOUT = NB_BYTE'(8'h54);
  localparam logic [NB_BYTE-1:0] RSP_ERR  = NB_BYTE'(8'h3F);

  typedef enum logic [3:0] {
    IDLE, LOAD_CNT, LOAD_BYTE, LOAD_WR, RUN, STEP,
    DUMP_ADDR, DUMP_CAP, TX, TX_WAIT
  } state_e;

  state_e              state_q;
  logic [NB_BYTE-1:0]  txData_q;
  logic                txValid_q;
  logic                clkEn_q;
  logic                resetPc_q;
  logic                wMem_q;
  logic [NB_REG-1:0]   addr_q;
  logic [NB_REG-1:0]   dataIf_q;
  logic [NB_REG-1:0]   shift_q;
  logic [NB_REG-1:0]   dumpWord_q;
  logic [NB_BYTE-1:0]  wordCnt_q;
  logic [NB_BYTE-1:0]  wordIdx_q;
  logic [1:0]          byteCnt_q;
  logic [31:0]         cycleCnt_q;
  logic                dumping_q;
  logic                dumpPass_q;
  logic [15:0]         dumpIdx_q;

  logic [NB_REG-1:0]   shift_d;
  logic [31:0]         cycleCnt_d;
  logic [15:0]         dumpIdx_d;

  // Incoming load bytes arrive MSB first, so each one enters at the bottom.
  assign shift_d    = {shift_q[NB_REG-NB_BYTE-1:0], i_rx_data};
  assign cycleCnt_d = cycleCnt_q + 32'd1;
  assign dumpIdx_d  = dumpIdx_q + 16'd1;

  // Single sequencer; every output is a register so the pipeline and the
  // host link never see combinational glitches from the command decode.
  // Responses are sent by loading txData_q/txValid_q and parking in TX_WAIT,
  // which holds the byte until the host accepts it. TX is only used by the
  // dump to present the next byte of the captured word.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= IDLE;
      txData_q   <= '0;
      txValid_q  <= 1'b0;
      clkEn_q    <= 1'b0;
      resetPc_q  <= 1'b1;
      wMem_q     <= 1'b0;
      addr_q     <= '0;
      dataIf_q   <= '0;
      shift_q    <= '0;
      dumpWord_q <= '0;
      wordCnt_q  <= '0;
      wordIdx_q  <= '0;
      byteCnt_q  <= '0;
      cycleCnt_q <= '0;
      dumping_q  <= 1'b0;
      dumpPass_q <= 1'b0;
      dumpIdx_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_rx_valid) begin
            if (i_rx_data == CMD_LOAD) begin
              resetPc_q <= 1'b1;
              state_q   <= LOAD_CNT;
            end else if (i_rx_data == CMD_RUN) begin
              resetPc_q  <= 1'b0;
              clkEn_q    <= 1'b1;
              cycleCnt_q <= '0;
              state_q    <= RUN;
            end else if (i_rx_data == CMD_STEP) begin
              resetPc_q <= 1'b0;
              clkEn_q   <= 1'b1;
              state_q   <= STEP;
            end else if (i_rx_data == CMD_DUMP) begin
              // Address is driven on entry so the read data lines up with DUMP_CAP.
              dumping_q  <= 1'b1;
              dumpPass_q <= 1'b0;
              dumpIdx_q  <= '0;
              addr_q     <= '0;
              state_q    <= DUMP_ADDR;
            end else begin
              txData_q  <= RSP_ERR;
              txValid_q <= 1'b1;
              state_q   <= TX_WAIT;
            end
          end
        end
        LOAD_CNT: begin
          if (i_rx_valid) begin
            if (i_rx_data == '0) begin
              txData_q  <= RSP_OK;
              txValid_q <= 1'b1;
              state_q   <= TX_WAIT;
            end else begin
              wordCnt_q <= i_rx_data;
              wordIdx_q <= '0;
              byteCnt_q <= '0;
              state_q   <= LOAD_BYTE;
            end
          end
        end
        LOAD_BYTE: begin
          if (i_rx_valid) begin
            shift_q   <= shift_d;
            byteCnt_q <= byteCnt_q + 2'd1;
            if (byteCnt_q == 2'd3) begin
              dataIf_q <= shift_d;
              addr_q   <= NB_REG'({wordIdx_q, 2'b00});
              wMem_q   <= 1'b1;
              state_q  <= LOAD_WR;
            end
          end
        end
        LOAD_WR: begin
          wMem_q    <= 1'b0;
          wordIdx_q <= wordIdx_q + NB_BYTE'(1);
          if (wordIdx_q == wordCnt_q - NB_BYTE'(1)) begin
            txData_q  <= RSP_OK;
            txValid_q <= 1'b1;
            state_q   <= TX_WAIT;
          end else begin
            state_q <= LOAD_BYTE;
          end
        end
        RUN: begin
          // Halt is checked first so it wins over a simultaneous timeout.
          cycleCnt_q <= cycleCnt_d;
          if (i_halt) begin
            clkEn_q   <= 1'b0;
            txData_q  <= RSP_HALT;
            txValid_q <= 1'b1;
            state_q   <= TX_WAIT;
          end else if (MAX_CYCLES != 0 && cycleCnt_d == MAX_C) begin
            clkEn_q   <= 1'b0;
            txData_q  <= RSP_TOUT;
            txValid_q <= 1'b1;
            state_q   <= TX_WAIT;
          end
        end
        STEP: begin
          clkEn_q   <= 1'b0;
          txData_q  <= i_halt ? RSP_HALT : RSP_OK;
          txValid_q <= 1'b1;
          state_q   <= TX_WAIT;
        end
        DUMP_ADDR: begin
          state_q <= DUMP_CAP;
        end
        DUMP_CAP: begin
          dumpWord_q <= dumpPass_q ? i_dunit_mem_data : i_dunit_reg;
          byteCnt_q  <= '0;
          state_q    <= TX;
        end
        TX: begin
          txData_q  <= dumpWord_q[NB_REG-1 -: NB_BYTE];
          txValid_q <= 1'b1;
          state_q   <= TX_WAIT;
        end
        TX_WAIT: begin
          if (i_tx_ready) begin
            txValid_q <= 1'b0;
            if (!dumping_q) begin
              state_q <= IDLE;
            end else if (byteCnt_q != 2'd3) begin
              dumpWord_q <= dumpWord_q << NB_BYTE;
              byteCnt_q  <= byteCnt_q + 2'd1;
              state_q    <= TX;
            end else if (!dumpPass_q && dumpIdx_q == 16'(NB_REGS - 1)) begin
              dumpPass_q <= 1'b1;
              dumpIdx_q  <= '0;
              addr_q     <= '0;
              state_q    <= DUMP_ADDR;
            end else if (dumpPass_q && dumpIdx_q == 16'(N_DMEM - 1)) begin
              dumping_q <= 1'b0;
              state_q   <= IDLE;
            end else begin
              dumpIdx_q <= dumpIdx_d;
              addr_q    <= dumpPass_q ? NB_REG'({dumpIdx_d, 2'b00}) : NB_REG'(dumpIdx_d);
              state_q   <= DUMP_ADDR;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_tx_data        = txData_q;
  assign o_tx_valid       = txValid_q;
  assign o_dunit_clk_en   = clkEn_q;
  assign o_dunit_reset_pc = resetPc_q;
  assign o_dunit_w_mem    = wMem_q;
  assign o_dunit_addr     = addr_q;
  assign o_dunit_data_if  = dataIf_q;
  assign o_busy           = (state_q != IDLE);

endmodule

// File: tb/tb_dunit_controller.sv
// tb_dunit_controller
// Directed bench for the debug-unit sequencer. Expected host bytes and
// instruction-memory writes are queued when a command is driven and popped by
// monitors when the DUT produces them. A small register-file/data-memory model
// supplies dump data with one cycle of read latency.
module tb_dunit_controller;

  logic        clk;
  logic        i_reset_n;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic        i_halt;
  logic [31:0] i_dunit_reg;
  logic [31:0] i_dunit_mem_data;
  logic        o_dunit_clk_en;
  logic        o_dunit_reset_pc;
  logic        o_dunit_w_mem;
  logic [31:0] o_dunit_addr;
  logic [31:0] o_dunit_data_if;
  logic        o_busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  txExp[$];
  logic [63:0] wExp[$];
  logic [7:0]  rxHist[$];
  int          clkEnCount = 0;
  int          wMemCount  = 0;
  logic        txPending  = 1'b0;
  logic [7:0]  txPrevData = 8'h00;
  logic        toggleReady = 1'b0;

  dunit_controller dut (
    .i_clk            (clk),
    .i_reset_n        (i_reset_n),
    .i_rx_data        (i_rx_data),
    .i_rx_valid       (i_rx_valid),
    .o_tx_data        (o_tx_data),
    .o_tx_valid       (o_tx_valid),
    .i_tx_ready       (i_tx_ready),
    .i_halt           (i_halt),
    .i_dunit_reg      (i_dunit_reg),
    .i_dunit_mem_data (i_dunit_mem_data),
    .o_dunit_clk_en   (o_dunit_clk_en),
    .o_dunit_reset_pc (o_dunit_reset_pc),
    .o_dunit_w_mem    (o_dunit_w_mem),
    .o_dunit_addr     (o_dunit_addr),
    .o_dunit_data_if  (o_dunit_data_if),
    .o_busy           (o_busy)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file holds k*0x11111111, data memory holds 0xA0000000+k.
  always @(posedge clk) begin
    i_dunit_reg      <= 32'h11111111 * {27'd0, o_dunit_addr[4:0]};
    i_dunit_mem_data <= 32'hA0000000 + {2'b00, o_dunit_addr[31:2]};
  end

  // Host ready is either always high or toggles every cycle during the dump.
  initial begin
    i_tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      i_tx_ready = toggleReady ? ~i_tx_ready : 1'b1;
    end
  end

  // Hang guard in case a wait is mis-bounded.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Scoreboard and protocol monitors, sampled on the falling edge.
  always @(negedge clk) begin
    if (i_reset_n) begin
      if (o_dunit_clk_en) clkEnCount++;
      checkOutput("wmem_clken_exclusive", 32'(o_dunit_w_mem & o_dunit_clk_en), 32'd0);
      if (txPending) begin
        checkOutput("tx_valid_held", 32'(o_tx_valid), 32'd1);
        checkOutput("tx_data_stable", 32'(o_tx_data), 32'(txPrevData));
      end
      if (o_tx_valid && i_tx_ready) begin
        checkOutput("tx_expected_present", 32'(txExp.size() != 0), 32'd1);
        if (txExp.size() != 0) checkOutput("tx_byte", 32'(o_tx_data), 32'(txExp.pop_front()));
        rxHist.push_back(o_tx_data);
      end
      if (o_dunit_w_mem) begin
        wMemCount++;
        checkOutput("wmem_reset_pc", 32'(o_dunit_reset_pc), 32'd1);
        checkOutput("wmem_expected_present", 32'(wExp.size() != 0), 32'd1);
        if (wExp.size() != 0) begin
          logic [63:0] e;
          e = wExp.pop_front();
          checkOutput("wmem_addr", o_dunit_addr, e[63:32]);
          checkOutput("wmem_data", o_dunit_data_if, e[31:0]);
        end
      end
      txPending  = o_tx_valid && !i_tx_ready;
      txPrevData = o_tx_data;
    end else begin
      txPending = 1'b0;
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents one host byte for exactly one cycle.
  task automatic applyStimulus(input logic [7:0] b);
    @(posedge clk);
    #1;
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(posedge clk);
    #1;
    i_rx_valid = 1'b0;
  endtask

  // Waits until all expected traffic has appeared and the DUT is idle.
  task automatic waitDrain(input string tag, input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clk);
      #1;
      if (txExp.size() == 0 && wExp.size() == 0 && !o_busy) done = 1'b1;
    end
    checkOutput(tag, 32'(done), 32'd1);
  endtask

  initial begin
    int base;
    int n;
    int histBase;
    int wBase;
    logic [31:0] w;

    i_reset_n  = 1'b0;
    i_rx_data  = 8'h00;
    i_rx_valid = 1'b0;
    i_halt     = 1'b0;
    idle(3);

    // Reset values.
    checkOutput("reset_busy", 32'(o_busy), 32'd0);
    checkOutput("reset_reset_pc", 32'(o_dunit_reset_pc), 32'd1);
    checkOutput("reset_clk_en", 32'(o_dunit_clk_en), 32'd0);
    checkOutput("reset_w_mem", 32'(o_dunit_w_mem), 32'd0);
    checkOutput("reset_tx_valid", 32'(o_tx_valid), 32'd0);
    checkOutput("reset_addr", o_dunit_addr, 32'd0);
    i_reset_n = 1'b1;
    idle(2);

    // Load two words.
    $display("[TB] load two words");
    wExp.push_back({32'h0, 32'h20010005});
    wExp.push_back({32'h4, 32'h20020005});
    txExp.push_back(8'h4B);
    applyStimulus(8'h4C);
    applyStimulus(8'h02);
    applyStimulus(8'h20); applyStimulus(8'h01); applyStimulus(8'h00); applyStimulus(8'h05);
    applyStimulus(8'h20); applyStimulus(8'h02); applyStimulus(8'h00); applyStimulus(8'h05);
    waitDrain("load_drain", 200);
    checkOutput("load_no_clk_en", 32'(clkEnCount), 32'd0);
    checkOutput("load_wmem_count", 32'(wMemCount), 32'd2);
    checkOutput("load_reset_pc_held", 32'(o_dunit_reset_pc), 32'd1);

    // Three single steps.
    $display("[TB] three steps");
    for (int s = 0; s < 3; s++) begin
      base = clkEnCount;
      txExp.push_back(8'h4B);
      applyStimulus(8'h53);
      waitDrain("step_drain", 50);
      checkOutput("step_clk_en_cycles", 32'(clkEnCount - base), 32'd1);
      checkOutput("step_reset_pc", 32'(o_dunit_reset_pc), 32'd0);
    end

    // Run until halt raised during the 7th enabled cycle.
    $display("[TB] run to halt");
    base = clkEnCount;
    txExp.push_back(8'h48);
    applyStimulus(8'h43);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      if (o_dunit_clk_en) n++;
      if (n == 7) begin
        i_halt = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    checkOutput("halt_raised", 32'(i_halt), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("halt_clk_en_dropped", 32'(o_dunit_clk_en), 32'd0);
    waitDrain("halt_drain", 100);
    checkOutput("halt_clk_en_cycles", 32'(clkEnCount - base), 32'd7);

    // Stepping after halt reports H.
    base = clkEnCount;
    txExp.push_back(8'h48);
    applyStimulus(8'h53);
    waitDrain("step_halted_drain", 50);
    checkOutput("step_halted_cycles", 32'(clkEnCount - base), 32'd1);
    i_halt = 1'b0;

    // Run to timeout; a byte sent mid-run must be dropped.
    $display("[TB] run to timeout");
    base = clkEnCount;
    txExp.push_back(8'h54);
    applyStimulus(8'h43);
    idle(5);
    applyStimulus(8'h58);
    waitDrain("timeout_drain", 1500);
    checkOutput("timeout_clk_en_cycles", 32'(clkEnCount - base), 32'd1024);

    // Unknown command.
    txExp.push_back(8'h3F);
    applyStimulus(8'h58);
    waitDrain("unknown_drain", 50);

    // Dump with a toggling ready.
    $display("[TB] dump");
    for (int k = 0; k < 32; k++) begin
      w = 32'h11111111 * 32'(k);
      for (int b = 3; b >= 0; b--) txExp.push_back(w[b*8 +: 8]);
    end
    for (int k = 0; k < 32; k++) begin
      w = 32'hA0000000 + 32'(k);
      for (int b = 3; b >= 0; b--) txExp.push_back(w[b*8 +: 8]);
    end
    histBase = rxHist.size();
    base = clkEnCount;
    toggleReady = 1'b1;
    applyStimulus(8'h52);
    waitDrain("dump_drain", 3000);
    toggleReady = 1'b0;
    idle(2);
    checkOutput("dump_byte_count", 32'(rxHist.size() - histBase), 32'd256);
    checkOutput("dump_no_clk_en", 32'(clkEnCount - base), 32'd0);
    if (rxHist.size() >= histBase + 129) begin
      for (int i = 4; i < 8; i++) checkOutput("dump_reg1_byte", 32'(rxHist[histBase + i]), 32'h11);
      checkOutput("dump_byte128", 32'(rxHist[histBase + 128]), 32'hA0);
    end

    // Async reset in the middle of a load.
    $display("[TB] reset mid-load");
    applyStimulus(8'h4C);
    applyStimulus(8'h01);
    applyStimulus(8'h20);
    applyStimulus(8'h01);
    checkOutput("midload_busy", 32'(o_busy), 32'd1);
    #3;
    i_reset_n = 1'b0;
    #1;
    checkOutput("midload_w_mem", 32'(o_dunit_w_mem), 32'd0);
    checkOutput("midload_reset_pc", 32'(o_dunit_reset_pc), 32'd1);
    checkOutput("midload_idle", 32'(o_busy), 32'd0);
    @(posedge clk);
    #1;
    i_reset_n = 1'b1;
    idle(2);

    // Zero-length load.
    $display("[TB] zero-length load");
    wBase = wMemCount;
    txExp.push_back(8'h4B);
    applyStimulus(8'h4C);
    applyStimulus(8'h00);
    n = 0;
    while (!o_tx_valid && n < 3) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("zero_load_k_prompt", 32'(o_tx_valid), 32'd1);
    waitDrain("zero_load_drain", 50);
    checkOutput("zero_load_no_wmem", 32'(wMemCount - wBase), 32'd0);

    checkOutput("tx_queue_empty", 32'(txExp.size()), 32'd0);
    checkOutput("wmem_queue_empty", 32'(wExp.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
